demux21_stream: RTL and testbench
=================================

Name: demux21_stream

Overview:
- Receiving end of a 2:1 multiplexed data path: takes one WIDTH-bit valid/ready input stream and routes each word to one of two output channels.
- Each output channel has a 2-entry FIFO.
- Routing is by an explicit per-word select (in_sel) or by an internal round-robin FSM (in_auto=1).
- Sits downstream of the 2:1 mux, so interleaved traffic can be split back into per-source streams.

Parameters:
- WIDTH, 2, data width of the input word and of each output channel.
- DEPTH, 2, entries per channel FIFO. Fixed at 2; a pointer width of 1 bit is assumed.

Ports:
- CLK  input  1  rising-edge clock.
- Reset_L  input  1  asynchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  1  target channel when in_auto=0 (0 = out0, 1 = out1).
- in_auto  input  1  1 = ignore in_sel; route by round-robin pointer.
- out0_valid  output  1  channel 0 head valid.
- out0_ready  input  1  channel 0 consumer accepts.
- out0_data  output  WIDTH  channel 0 head word.
- out1_valid  output  1  channel 1 head valid.
- out1_ready  input  1  channel 1 consumer accepts.
- out1_data  output  WIDTH  channel 1 head word.

Behaviour:
- Reset (Reset_L=0, asynchronous, takes effect immediately):
  - Both FIFOs emptied; out0_valid=out1_valid=0; out0_data=out1_data=0.
  - Round-robin state = RR_CH0; all pointers and counts = 0.
  - Reset asserted mid-transfer discards all buffered words; no partial state survives.
- Target channel (combinational): tgt = in_auto ? rr_state : in_sel.
- in_ready = (count of tgt FIFO < 2). Combinational from tgt and registered counts; does not depend on outN_ready (no bypass).
- Push: in_valid && in_ready at the rising edge writes in_data into the tgt FIFO tail.
- Pop: outN_valid && outN_ready pops the channel-N head. outN_data = head word, stable while outN_valid=1 and not popped.
- Latency: word accepted at edge k appears on outN_data/outN_valid after edge k (one cycle). No combinational in->out path.
- Push and pop on the same channel in the same cycle:
  - count=1: count stays 1; the new word becomes head after the old one leaves.
  - count=2: push is impossible because in_ready=0. A pop in that cycle frees a slot only for the next cycle.
  - count=0: push only; count becomes 1.
- Both channels may pop in the same cycle. Channels are independent except for the shared input.
- Round-robin FSM, states RR_CH0 and RR_CH1:
  - Transition RR_CH0<->RR_CH1 only on an accepted input word while in_auto=1.
  - Holds when in_auto=0, and when in_valid=1 with in_ready=0 (target full stalls; no skipping to the other channel).
  - A change of in_auto takes effect combinationally on tgt; rr_state is retained across mode changes.
- Changing in_valid/in_sel/in_data while in_valid=1 and in_ready=0 is permitted; the value sampled at the accepting edge is what gets stored.
- FIFO pointers wrap modulo 2. Count range 0..2 (2 bits).

Optional Feature:
- Macro: DEMUX21_STATS_EN.
- When defined:
  - Adds output ports cnt0 and cnt1 (8 bits each) that count words popped from each channel.
  - Counters saturate at 255 and reset to 0.
  - Adds input stats_clr (1 bit): synchronous clear of both counters. Clear has priority over an increment in the same cycle.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package demux21_pkg:
  - Constants RR_CH0=1'b0, RR_CH1=1'b1.
  - Constant CH_DEPTH=2.
  - Count width localparam (2).
- One sub-module, demux21_fifo2: a 2-entry valid/ready FIFO with push, pop, full, empty, count and head data. Instantiated twice.
- The top holds the tgt logic, the round-robin FSM and the optional stats counters.

Test Plan:
- Reset check: Reset_L=0 mid-stream with both FIFOs holding data -> immediately out0_valid=out1_valid=0, data=0, in_ready=1; after release, first word in_sel=1 goes to out1.
- Explicit routing (WIDTH=2, in_auto=0, outN_ready=1): words 0,1,2,3 with sel=0 then 0,1,2,3 with sel=1 -> each word appears on out0 (first four) or out1 (last four) one cycle after acceptance, in order, never on the other channel.
- Backpressure: out0_ready=0, push 3 words with sel=0 -> first two accepted, third sees in_ready=0. Raise out0_ready for one cycle -> head pops; third word accepted the following cycle; order preserved 1,2,3.
- Round-robin: in_auto=1, push 1,2,3,4 -> out0 gets 1,3 and out1 gets 2,4. With out1 full and rr_state=RR_CH1: in_ready=0, rr_state holds, nothing goes to out0.
- Simultaneous push/pop: channel 0 count=1, push with sel=0 while out0_ready=1 -> count stays 1; old head leaves; new word is head next cycle.
- DEMUX21_STATS_EN: pop 300 words on ch0 -> cnt0=255 (saturated). stats_clr asserted in the same cycle as a pop -> cnt0=0.

Source files
------------

// File: rtl/demux21_pkg.sv
// Shared types and constants for the demux21_stream 1:2 stream splitter.
package demux21_pkg;

    typedef enum logic {
        RR_CH0 = 1'b0,
        RR_CH1 = 1'b1
    } rrState_e;

    localparam int CH_DEPTH = 2;
    localparam int CNT_W    = 2;

    // Internal state exposed for observation: round-robin pointer and channel occupancy.
    typedef struct packed {
        rrState_e         rrState;
        logic [CNT_W-1:0] count0;
        logic [CNT_W-1:0] count1;
    } dbg_t;

    function automatic rrState_e rrToggle(input rrState_e s);
        return (s == RR_CH0) ? RR_CH1 : RR_CH0;
    endfunction

endpackage

// File: rtl/demux21_fifo2.sv
// Two-entry valid/ready FIFO: push/pop strobes, full/empty flags, occupancy count
// and a registered head word (zero while empty).
module demux21_fifo2
    import demux21_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] headData
);

    logic [WIDTH-1:0] mem [CH_DEPTH];
    logic             wrPtr;
    logic             rdPtr;
    logic             pushEn;
    logic             popEn;

    assign full   = (count == CNT_W'(CH_DEPTH));
    assign empty  = (count == '0);
    assign pushEn = push && !full;
    assign popEn  = pop && !empty;

    // Head is forced to zero while empty so a drained channel shows no stale word.
    assign headData = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < CH_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
            count <= '0;
        end else begin
            if (pushEn) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= ~wrPtr;
            end
            if (popEn) begin
                rdPtr <= ~rdPtr;
            end
            count <= count + CNT_W'(pushEn) - CNT_W'(popEn);
        end
    end

endmodule

// File: rtl/demux21_stream.sv
// Splits one valid/ready stream into two buffered channels, routed by in_sel or a
// round-robin pointer (in_auto). Define DEMUX21_STATS_EN for per-channel pop counters.
module demux21_stream
    import demux21_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_auto,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
`ifdef DEMUX21_STATS_EN
    input  logic             stats_clr,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1,
`endif
    output dbg_t             dbg
);

    rrState_e         rrState;
    rrState_e         rrNext;
    logic             tgt;
    logic             accept;
    logic             full0;
    logic             full1;
    logic             empty0;
    logic             empty1;
    logic [CNT_W-1:0] count0;
    logic [CNT_W-1:0] count1;
    logic             pop0;
    logic             pop1;

    assign tgt        = in_auto ? logic'(rrState) : in_sel;
    // Readiness depends only on registered occupancy, never on the consumers.
    assign in_ready   = tgt ? !full1 : !full0;
    assign accept     = in_valid && in_ready;
    assign out0_valid = !empty0;
    assign out1_valid = !empty1;
    assign pop0       = out0_valid && out0_ready;
    assign pop1       = out1_valid && out1_ready;

    demux21_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
        .clk      (CLK),
        .rstN     (Reset_L),
        .push     (accept && !tgt),
        .pushData (in_data),
        .pop      (pop0),
        .full     (full0),
        .empty    (empty0),
        .count    (count0),
        .headData (out0_data)
    );

    demux21_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
        .clk      (CLK),
        .rstN     (Reset_L),
        .push     (accept && tgt),
        .pushData (in_data),
        .pop      (pop1),
        .full     (full1),
        .empty    (empty1),
        .count    (count1),
        .headData (out1_data)
    );

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            rrState <= RR_CH0;
        end else begin
            rrState <= rrNext;
        end
    end

    // Advance only on an accepted word in auto mode; a full target stalls the pointer.
    always_comb begin
        rrNext = rrState;
        if (accept && in_auto) begin
            rrNext = rrToggle(rrState);
        end
    end

    assign dbg = '{rrState: rrState, count0: count0, count1: count1};

`ifdef DEMUX21_STATS_EN
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (stats_clr) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (pop0 && (cnt0 != 8'hFF)) cnt0 <= cnt0 + 8'd1;
            if (pop1 && (cnt1 != 8'hFF)) cnt1 <= cnt1 + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux21_stream.sv
// Bench for demux21_stream: per-channel expected queues filled on accepted words and
// drained on pops, with occupancy/ready/round-robin predicted from the bench's own model.
module tb_demux21_stream;
    import demux21_pkg::*;

    localparam int WIDTH = 2;

    logic             CLK;
    logic             Reset_L;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_auto;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    dbg_t             dbg;
`ifdef DEMUX21_STATS_EN
    logic             stats_clr;
    logic [7:0]       cnt0;
    logic [7:0]       cnt1;
    int               statModel0;
    int               statModel1;
`endif

    logic [WIDTH-1:0] expQ0[$];
    logic [WIDTH-1:0] expQ1[$];
    logic             rrModel;
    logic             tgtModel;
    logic             readyModel;
    int               nChecks;
    int               nFail;

    demux21_stream #(.WIDTH(WIDTH)) dut (
        .CLK        (CLK),
        .Reset_L    (Reset_L),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_auto    (in_auto),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
`ifdef DEMUX21_STATS_EN
        .stats_clr  (stats_clr),
        .cnt0       (cnt0),
        .cnt1       (cnt1),
`endif
        .dbg        (dbg)
    );

    // Clock and watchdog
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard: compare against the model, then apply this cycle's pops and pushes.
    always @(negedge CLK) begin
        if (!Reset_L) begin
            expQ0.delete();
            expQ1.delete();
            rrModel = 1'b0;
`ifdef DEMUX21_STATS_EN
            statModel0 = 0;
            statModel1 = 0;
`endif
        end else begin
            checkVal("out0_valid", out0_valid, expQ0.size() > 0);
            checkVal("out1_valid", out1_valid, expQ1.size() > 0);
            if (expQ0.size() > 0) checkVal("out0_data", out0_data, expQ0[0]);
            if (expQ1.size() > 0) checkVal("out1_data", out1_data, expQ1[0]);
            checkVal("rr_state", dbg.rrState, rrModel);
            checkVal("count0", dbg.count0, expQ0.size());
            checkVal("count1", dbg.count1, expQ1.size());
            tgtModel   = in_auto ? rrModel : in_sel;
            readyModel = (tgtModel ? expQ1.size() : expQ0.size()) < CH_DEPTH;
            checkVal("in_ready", in_ready, readyModel);
`ifdef DEMUX21_STATS_EN
            checkVal("cnt0", cnt0, statModel0);
            checkVal("cnt1", cnt1, statModel1);
            if (stats_clr) begin
                statModel0 = 0;
                statModel1 = 0;
            end else begin
                if (out0_valid && out0_ready && statModel0 < 255) statModel0++;
                if (out1_valid && out1_ready && statModel1 < 255) statModel1++;
            end
`endif
            if (out0_valid && out0_ready && expQ0.size() > 0) void'(expQ0.pop_front());
            if (out1_valid && out1_ready && expQ1.size() > 0) void'(expQ1.pop_front());
            if (in_valid && in_ready) begin
                if (tgtModel) expQ1.push_back(in_data);
                else          expQ0.push_back(in_data);
                if (in_auto) rrModel = ~rrModel;
            end
        end
    end

    // Drivers
    task automatic sendWord(input logic [WIDTH-1:0] d, input logic s, input logic a);
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        in_auto  = a;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (in_ready) begin
                @(posedge CLK);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge CLK);
            #1;
        end
        checkVal("send_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drain();
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        idle(4);
    endtask

    initial begin
        nChecks    = 0;
        nFail      = 0;
        Reset_L    = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_sel     = 1'b0;
        in_auto    = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
`ifdef DEMUX21_STATS_EN
        stats_clr  = 1'b0;
`endif
        idle(3);
        checkVal("rst_out0_valid", out0_valid, 0);
        checkVal("rst_out1_valid", out1_valid, 0);
        checkVal("rst_in_ready", in_ready, 1);
        Reset_L = 1'b1;
        idle(1);

        // Explicit routing, consumers always ready
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 4; i++) sendWord(WIDTH'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) sendWord(WIDTH'(i), 1'b1, 1'b0);
        drain();

        // Backpressure: third word stalls until a single-cycle pop frees a slot
        out0_ready = 1'b0;
        sendWord(2'd1, 1'b0, 1'b0);
        sendWord(2'd2, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 2'd3;
        in_sel   = 1'b0;
        idle(2);
        checkVal("bp_in_ready_low", in_ready, 0);
        out0_ready = 1'b1;
        @(negedge CLK);
        checkVal("bp_ready_during_pop", in_ready, 0);
        @(posedge CLK);
        #1;
        out0_ready = 1'b0;
        sendWord(2'd3, 1'b0, 1'b0);
        idle(2);
        drain();

        // Round-robin, then a full target that must stall the pointer
        for (int i = 1; i <= 4; i++) sendWord(WIDTH'(i), 1'b0, 1'b1);
        drain();
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        sendWord(2'd1, 1'b0, 1'b1);
        sendWord(2'd2, 1'b1, 1'b0);
        sendWord(2'd3, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = 2'd0;
        in_auto  = 1'b1;
        idle(3);
        checkVal("rr_stall_ready", in_ready, 0);
        checkVal("rr_stall_state", dbg.rrState, RR_CH1);
        checkVal("rr_stall_count0", dbg.count0, 1);
        in_valid = 1'b0;
        drain();

        // Simultaneous push and pop on a single-entry channel
        out0_ready = 1'b0;
        sendWord(2'd2, 1'b0, 1'b0);
        out0_ready = 1'b1;
        sendWord(2'd1, 1'b0, 1'b0);
        out0_ready = 1'b0;
        @(negedge CLK);
        checkVal("sim_count0", dbg.count0, 1);
        checkVal("sim_head", out0_data, 2'd1);
        idle(1);
        drain();

        // Random traffic with inputs changing under backpressure
        for (int i = 0; i < 200; i++) begin
            out0_ready = 1'($urandom_range(0, 1));
            out1_ready = 1'($urandom_range(0, 1));
            in_valid   = 1'($urandom_range(0, 1));
            in_data    = WIDTH'($urandom_range(0, 3));
            in_sel     = 1'($urandom_range(0, 1));
            in_auto    = 1'($urandom_range(0, 1));
            idle(1);
        end
        drain();

        // Asynchronous reset with both channels holding data
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        in_auto    = 1'b0;
        sendWord(2'd1, 1'b0, 1'b0);
        sendWord(2'd2, 1'b1, 1'b0);
        sendWord(2'd3, 1'b1, 1'b0);
        @(posedge CLK);
        #3;
        Reset_L = 1'b0;
        #1;
        checkVal("arst_out0_valid", out0_valid, 0);
        checkVal("arst_out1_valid", out1_valid, 0);
        checkVal("arst_out0_data", out0_data, 0);
        checkVal("arst_out1_data", out1_data, 0);
        checkVal("arst_in_ready", in_ready, 1);
        checkVal("arst_rr", dbg.rrState, RR_CH0);
        @(posedge CLK);
        #1;
        Reset_L = 1'b1;
        sendWord(2'd3, 1'b1, 1'b0);
        @(negedge CLK);
        checkVal("post_rst_out1_valid", out1_valid, 1);
        checkVal("post_rst_out0_valid", out0_valid, 0);
        checkVal("post_rst_out1_data", out1_data, 2'd3);
        drain();

`ifdef DEMUX21_STATS_EN
        // Saturation after 300 pops, then clear winning over a same-cycle pop
        for (int i = 0; i < 300; i++) sendWord(WIDTH'(i), 1'b0, 1'b0);
        idle(3);
        checkVal("stat_sat", cnt0, 8'd255);
        out0_ready = 1'b0;
        sendWord(2'd1, 1'b0, 1'b0);
        out0_ready = 1'b1;
        stats_clr  = 1'b1;
        idle(1);
        stats_clr  = 1'b0;
        out0_ready = 1'b0;
        @(negedge CLK);
        checkVal("stat_clr", cnt0, 8'd0);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
